fir_lp_out_fmt: RTL and testbench
=================================

// Module: fir_lp_out_fmt
// PURPOSE
//  Output end of the low-pass FIR stream. Accepts 32-bit FIR output beats (tag[31:16], int16 sample[15:0]),
//  converts the sample back to offset-binary uint16, optionally decimates, and buffers kept beats in a FIFO
//  toward the downstream AXI-Stream consumer. The FIR is never back-pressured: beats arriving when the FIFO
//  is full are dropped and counted.
// PARAMETERS
//  FIFO_DEPTH  16  buffer entries, power of 2, >= 2
//  CNT_W       32  width of sample_cnt
// PORTS
//  aclk           in   1      clock; all logic on rising edge
//  areset         in   1      asynchronous, active-high reset
//  dec_ratio      in   8      keep 1 of every dec_ratio beats; 0 and 1 both mean keep all
//  cnt_clear      in   1      synchronous clear of counters and decimation phase
//  s_axis_tdata   in   32     FIR output: [31:16] tag, [15:0] int16 sample
//  s_axis_tvalid  in   1      input beat valid
//  s_axis_tready  out  1      input ready
//  m_axis_tdata   out  32     [31:16] tag, [15:0] uint16 offset-binary sample
//  m_axis_tvalid  out  1      output beat valid
//  m_axis_tready  in   1      downstream ready
//  overflow_cnt   out  16     kept beats dropped on FIFO full, saturating
//  sample_cnt     out  CNT_W  accepted input beats, wrapping
// BEHAVIOUR
//  Reset: while areset high, s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata=0, overflow_cnt=0,
//   sample_cnt=0, FIFO empty, decimation phase=0. s_axis_tready goes 1 on first edge after release, stays 1.
//  Accept: input beat accepted when s_axis_tvalid & s_axis_tready; sample_cnt += 1 (mod 2^CNT_W).
//  Format: out[31:16]=in[31:16]; out[15:0]=in[15:0] + 16'h8000 mod 2^16 (MSB inverted), no saturation.
//  Decimation: phase counter 0..R-1, R=max(dec_ratio,1); advances on each accepted beat, wraps to 0
//   after R-1. Beat is kept when phase==0 before advance. dec_ratio registered internally; any change
//   forces phase=0 on the next edge, so the first beat after a change is kept.
//  Push: kept beat written at the accept edge if FIFO not full. Full = count==FIFO_DEPTH evaluated
//   before this cycle's pop; a pop in the same cycle does NOT make room -> beat dropped,
//   overflow_cnt += 1 unless already 16'hFFFF.
//  Output: first-word-fall-through. m_axis_tvalid = FIFO not empty, m_axis_tdata = head entry,
//   both registered. Latency: beat accepted at edge N into empty FIFO -> valid from edge N (visible
//   the following cycle). Pop on m_axis_tvalid & m_axis_tready; order preserved.
//  AXI rules: once asserted, m_axis_tvalid stays high and m_axis_tdata stable until handshake.
//  Simultaneous push+pop on non-full, non-empty FIFO: count unchanged. Push into empty with no pop:
//   count 0->1. Pointers wrap modulo FIFO_DEPTH.
//  cnt_clear: next edge sets overflow_cnt=0, sample_cnt=0, phase=0; the beat accepted in the same
//   cycle is not counted and is treated as phase 0 (kept). FIFO contents and m_axis unaffected.
//  Reset mid-operation: asynchronous; FIFO contents discarded, m_axis_tvalid drops immediately.
// TESTING
//  1 reset asserted with traffic -> all outputs 0, s_axis_tready 0; release -> tready 1 after one edge.
//  2 dec_ratio=1, inputs 0x0001_0000, 0x0002_FFFF, 0x0003_7FFF, 0x0004_8000 -> outputs 0x0001_8000,
//    0x0002_7FFF, 0x0003_FFFF, 0x0004_0000 in order, first valid one cycle after accept.
//  3 dec_ratio=4, 12 back-to-back beats tags 0..11 -> only tags 0,4,8 emitted; sample_cnt=12.
//  4 m_axis_tready=0, 20 beats, FIFO_DEPTH=16 -> 16 stored, overflow_cnt=4; then tready=1 -> tags 0..15
//    emitted, tdata stable while stalled.
//  5 FIFO full, push and pop same cycle -> push dropped, overflow_cnt+1, count becomes 15.
//  6 areset pulse mid-burst -> m_axis_tvalid low same cycle, counters 0; change dec_ratio 4->2 mid-run
//    -> next accepted beat kept.

Source files
------------

// File: rtl/fir_lp_out_fmt.sv
// Output formatter for the low-pass FIR stream: int16 to offset-binary conversion,
// optional 1-of-R decimation and a first-word-fall-through FIFO toward AXI-Stream.
module fir_lp_out_fmt #(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 32
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic [7:0]       dec_ratio,
  input  logic             cnt_clear,
  input  logic [31:0]      s_axis_tdata,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  output logic [31:0]      m_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic [15:0]      overflow_cnt,
  output logic [CNT_W-1:0] sample_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  logic [31:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             tready_q;
  logic [7:0]       dec_q, phase_q, phase_d, phase_last;
  logic [15:0]      ovf_q, ovf_d;
  logic [CNT_W-1:0] scnt_q, scnt_d;
  logic             acc, changed, keep, full, push, drop, pop;

  function automatic logic [31:0] to_offset_bin(input logic [31:0] beat);
    return {beat[31:16], beat[15:0] ^ 16'h8000};
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    acc        = s_axis_tvalid & tready_q;
    changed    = (dec_ratio != dec_q);
    keep       = (phase_q == 8'd0) | changed | cnt_clear;
    full       = (count_q == DEPTH_C);
    push       = acc & keep & ~full;
    drop       = acc & keep & full;
    pop        = (count_q != '0) & m_axis_tready;
    count_d    = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    phase_last = (dec_q <= 8'd1) ? 8'd0 : dec_q - 8'd1;

    phase_d = phase_q;
    if (cnt_clear || changed)
      phase_d = 8'd0;
    else if (acc)
      phase_d = (phase_q >= phase_last) ? 8'd0 : phase_q + 8'd1;

    ovf_d = ovf_q;
    if (cnt_clear)
      ovf_d = '0;
    else if (drop)
      ovf_d = sat_inc16(ovf_q);

    scnt_d = scnt_q;
    if (cnt_clear)
      scnt_d = '0;
    else if (acc)
      scnt_d = scnt_q + 1'b1;
  end

  // Control state: pointers, occupancy, decimation phase and counters
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      tready_q <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dec_q    <= '0;
      phase_q  <= '0;
      ovf_q    <= '0;
      scnt_q   <= '0;
    end else begin
      tready_q <= 1'b1;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q  <= count_d;
      dec_q    <= dec_ratio;
      phase_q  <= phase_d;
      ovf_q    <= ovf_d;
      scnt_q   <= scnt_d;
    end
  end

  // Storage array carries no reset; occupancy alone decides what is valid
  always_ff @(posedge aclk) begin
    if (push) mem_q[wr_ptr_q] <= to_offset_bin(s_axis_tdata);
  end

  assign s_axis_tready = tready_q;
  assign m_axis_tvalid = (count_q != '0);
  assign m_axis_tdata  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign overflow_cnt  = ovf_q;
  assign sample_cnt    = scnt_q;
endmodule

// File: tb/tb_fir_lp_out_fmt.sv
// Bench for fir_lp_out_fmt: directed scenarios plus random traffic against a queue-based model.
module tb_fir_lp_out_fmt;
  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic [7:0]  dec_ratio = 8'd1;
  logic        cnt_clear = 1'b0;
  logic [31:0] s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b0;
  logic [15:0] ovf;
  logic [31:0] scnt;

  fir_lp_out_fmt #(.FIFO_DEPTH(16), .CNT_W(32)) dut (
    .aclk(aclk), .areset(areset), .dec_ratio(dec_ratio), .cnt_clear(cnt_clear),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .overflow_cnt(ovf), .sample_cnt(scnt)
  );

  always #5 aclk = ~aclk;

  int passed = 0;
  int total  = 0;

  logic [31:0] mq[$];
  int          m_ovf, m_scnt, m_phase, m_last_dec, pops;
  bit          m_rdy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf = 0; m_scnt = 0; m_phase = 0; m_last_dec = 0; m_rdy = 0;
  endtask

  // Reference behaviour for the upcoming rising edge, from the state after the previous one
  task automatic model_edge();
    bit acc, chg, keep, full;
    int r;
    if (areset) return;
    acc  = s_tvalid && m_rdy;
    chg  = (int'(dec_ratio) != m_last_dec);
    keep = (m_phase == 0) || chg || cnt_clear;
    full = (mq.size() == 16);
    if (mq.size() != 0 && m_tready) begin
      void'(mq.pop_front());
      pops++;
    end
    if (acc && keep) begin
      if (!full) mq.push_back({s_tdata[31:16], s_tdata[15:0] + 16'h8000});
      else if (m_ovf != 65535) m_ovf++;
    end
    if (cnt_clear) begin
      m_ovf = 0; m_scnt = 0;
    end else if (acc) m_scnt++;
    r = (m_last_dec <= 1) ? 1 : m_last_dec;
    if (cnt_clear || chg) m_phase = 0;
    else if (acc) m_phase = (m_phase + 1) % r;
    m_last_dec = int'(dec_ratio);
    m_rdy = 1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_tready"}, {31'd0, s_tready}, {31'd0, m_rdy});
    chk({tag, "_tvalid"}, {31'd0, m_tvalid}, {31'd0, mq.size() != 0});
    chk({tag, "_tdata"}, m_tdata, (mq.size() != 0) ? mq[0] : 32'd0);
    chk({tag, "_ovf"}, {16'd0, ovf}, m_ovf);
    chk({tag, "_scnt"}, scnt, m_scnt);
  endtask

  task automatic tick(input string tag);
    model_edge();
    @(posedge aclk);
    @(negedge aclk);
    check_all(tag);
  endtask

  task automatic beat(input string tag, input logic [15:0] tg, input logic [15:0] smp);
    s_tdata = {tg, smp}; s_tvalid = 1'b1;
    tick(tag);
    s_tvalid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    m_tready = 1'b1; s_tvalid = 1'b0;
    while (mq.size() != 0 && n < 100) begin
      tick(tag);
      n++;
    end
    if (n >= 100) chk({tag, "_drain_timeout"}, mq.size(), 0);
    m_tready = 1'b0;
  endtask

  task automatic set_dec(input logic [7:0] d);
    dec_ratio = d; s_tvalid = 1'b0;
    tick("dec_change");
  endtask

  initial begin
    logic [31:0] vin [4];
    vin[0] = 32'h0001_0000; vin[1] = 32'h0002_FFFF; vin[2] = 32'h0003_7FFF; vin[3] = 32'h0004_8000;
    model_reset();
    pops = 0;

    // 1: reset held while traffic is offered
    s_tvalid = 1'b1; s_tdata = 32'h1234_5678; m_tready = 1'b1;
    repeat (3) tick("rst_hold");
    @(negedge aclk);
    areset = 1'b0;
    #1;
    chk("rst_rel_tready_before_edge", {31'd0, s_tready}, 32'd0);
    s_tvalid = 1'b0; m_tready = 1'b0;
    @(negedge aclk);
    #0;
    model_edge();
    check_all("rst_rel");
    chk("rst_rel_tready_one", {31'd0, s_tready}, 32'd1);

    // 2: format with dec_ratio=1
    for (int i = 0; i < 4; i++) beat("fmt", vin[i][31:16], vin[i][15:0]);
    chk("fmt_first_const", m_tdata, 32'h0001_8000);
    m_tready = 1'b1; tick("fmt_pop");
    chk("fmt_second_const", m_tdata, 32'h0002_7FFF);
    drain("fmt_drain");

    // 3: dec_ratio=4, 12 beats
    set_dec(8'd4);
    cnt_clear = 1'b1; tick("clr"); cnt_clear = 1'b0;
    for (int i = 0; i < 12; i++) beat("dec4", 16'(i), 16'($urandom));
    chk("dec4_scnt12", scnt, 32'd12);
    pops = 0;
    drain("dec4_drain");
    chk("dec4_kept3", pops, 3);

    // 4: stalled downstream, 20 beats
    set_dec(8'd1);
    cnt_clear = 1'b1; tick("clr"); cnt_clear = 1'b0;
    for (int i = 0; i < 20; i++) beat("ovf", 16'(i), 16'($urandom));
    chk("ovf_is4", {16'd0, ovf}, 32'd4);
    pops = 0;
    drain("ovf_drain");
    chk("ovf_drained16", pops, 16);

    // 5: full FIFO, push and pop together
    for (int i = 0; i < 16; i++) beat("full", 16'(100 + i), 16'($urandom));
    m_tready = 1'b1;
    beat("full_pushpop", 16'hBEEF, 16'h0);
    chk("full_ovf5", {16'd0, ovf}, 32'd5);
    pops = 0;
    drain("full_drain");
    chk("full_left15", pops, 15);

    // 6: asynchronous reset mid-burst, then ratio change 4->2
    for (int i = 0; i < 5; i++) beat("burst", 16'(i), 16'($urandom));
    #2 areset = 1'b1;
    #1;
    model_reset();
    chk("arst_tvalid", {31'd0, m_tvalid}, 32'd0);
    chk("arst_tdata", m_tdata, 32'd0);
    chk("arst_scnt", scnt, 32'd0);
    chk("arst_ovf", {16'd0, ovf}, 32'd0);
    @(negedge aclk);
    areset = 1'b0;
    dec_ratio = 8'd4;
    tick("arst_rel");
    tick("dec4_settle");
    beat("ch_a", 16'h0A, 16'h1);
    beat("ch_b", 16'h0B, 16'h2);
    drain("ch_drain");
    set_dec(8'd2);
    beat("ch_kept", 16'h0C, 16'h3);
    chk("ch_kept_valid", {31'd0, m_tvalid}, 32'd1);
    chk("ch_kept_tag", {16'd0, m_tdata[31:16]}, 32'h0C);
    drain("ch_drain2");

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      s_tvalid  = 1'($urandom_range(0, 1));
      s_tdata   = $urandom;
      m_tready  = ($urandom_range(0, 3) == 0);
      cnt_clear = ($urandom_range(0, 40) == 0);
      if ($urandom_range(0, 30) == 0) dec_ratio = 8'($urandom_range(0, 5));
      tick("rand");
    end
    cnt_clear = 1'b0;
    drain("rand_drain");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
